mem_stage_lsu: RTL

- Parametrised successor to the single-cycle memory stage. Sits between the EX/MEM and MEM/WB pipeline registers.
- Talks to data memory over a valid/ready request channel plus a response-valid channel, so memories with variable latency are supported.
- Back-pressures EX with a ready signal.
- Handles byte/half/word accesses (and double/unsigned-word when XLEN=64): lane steering, sign/zero extension, misalignment trapping, response timeout.
- All MEM/WB outputs are registered.

---
 rtl/mem_stage_lsu_if.sv | 24 ++
 rtl/mem_stage_lsu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port of the load/store stage: valid/ready request channel plus a response-valid channel.
interface mem_stage_lsu_if #(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN/8-1:0] req_be;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;

  // Request transfers on req_valid && req_ready; while req_valid && !req_ready every req_* field holds.
  // Each accepted read returns one rsp_rdata beat flagged by rsp_valid, no earlier than the cycle after transfer.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Pipeline memory stage: steers loads/stores onto a variable-latency data-memory port, traps
// misaligned or illegal accesses and load-response timeouts, and registers every MEM/WB output.
module mem_stage_lsu #(
  parameter int XLEN        = 32,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // An EX entry is taken on ex_valid_i && ex_ready_o; ex_ready_o is high only in IDLE out of reset.
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [XLEN-1:0]   ex_alu_result_i,
  input  logic [XLEN-1:0]   ex_rs2_data_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_mem_write_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic              ex_reg_write_i,
  input  logic [1:0]        ex_result_src_i,
  input  logic [4:0]        ex_rd_addr_i,
  input  logic [XLEN-1:0]   ex_pc_plus_4_i,
  mem_stage_lsu_if.master   dmem,
  output logic              wb_valid_o,
  output logic              wb_reg_write_o,
  output logic [1:0]        wb_result_src_o,
  output logic [XLEN-1:0]   wb_read_data_o,
  output logic [XLEN-1:0]   wb_alu_result_o,
  output logic [XLEN-1:0]   wb_pc_plus_4_o,
  output logic [4:0]        wb_rd_addr_o,
  output logic              exc_misalign_o,
  output logic              exc_bus_err_o,
  output logic [XLEN-1:0]   exc_addr_o,
  output logic [1:0]        dbg_state_o
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RSP = 2'd2} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   addr_q, pc4_q;
  logic [2:0]        f3_q;
  logic              reg_write_q;
  logic [1:0]        result_src_q;
  logic [4:0]        rd_q;
  logic              req_valid_q, req_we_q;
  logic [XLEN-1:0]   req_addr_q, req_wdata_q;
  logic [NB-1:0]     req_be_q;
  logic              wb_valid_q, wb_reg_write_q;
  logic [1:0]        wb_result_src_q;
  logic [XLEN-1:0]   wb_read_data_q, wb_alu_result_q, wb_pc_plus_4_q, exc_addr_q;
  logic [4:0]        wb_rd_addr_q;
  logic              exc_misalign_q, exc_bus_err_q;

  logic              is_mem, illegal, misal, timeout_hit;
  logic [OFFW-1:0]   in_off, ld_off;
  logic [NB-1:0]     be_d;
  logic [XLEN-1:0]   wdata_d, ld_shift, ld_data_d;

  assign is_mem      = ex_mem_read_i || ex_mem_write_i;
  assign in_off      = ex_alu_result_i[OFFW-1:0];
  assign ld_off      = addr_q[OFFW-1:0];
  assign timeout_hit = (RSP_TIMEOUT > 0) && (cnt_q == CNT_LAST);

  // D and WU only exist on the 64-bit datapath; funct3 111 is never a valid access.
  always_comb begin
    illegal = (ex_funct3_i == 3'b111) ||
              ((XLEN == 32) && ((ex_funct3_i[1:0] == 2'b11) || (ex_funct3_i == 3'b110)));
    misal   = 1'b0;
    be_d    = '1;
    wdata_d = ex_rs2_data_i;
    unique case (ex_funct3_i[1:0])
      2'b00: begin
        be_d    = NB'(1) << in_off;
        wdata_d = {NB{ex_rs2_data_i[7:0]}};
      end
      2'b01: begin
        misal   = ex_alu_result_i[0];
        be_d    = NB'(2'b11) << in_off;
        wdata_d = {(XLEN/16){ex_rs2_data_i[15:0]}};
      end
      2'b10: begin
        misal   = |ex_alu_result_i[1:0];
        be_d    = NB'(4'hF) << in_off;
        wdata_d = {(XLEN/32){ex_rs2_data_i[31:0]}};
      end
      default: misal = |ex_alu_result_i[2:0];
    endcase
  end

  always_comb begin
    ld_shift  = dmem.rsp_rdata >> {ld_off, 3'b000};
    ld_data_d = ld_shift;
    unique case (f3_q)
      3'b000:  ld_data_d = XLEN'($signed(ld_shift[7:0]));
      3'b001:  ld_data_d = XLEN'($signed(ld_shift[15:0]));
      3'b010:  ld_data_d = XLEN'($signed(ld_shift[31:0]));
      3'b100:  ld_data_d = XLEN'(ld_shift[7:0]);
      3'b101:  ld_data_d = XLEN'(ld_shift[15:0]);
      3'b110:  ld_data_d = XLEN'(ld_shift[31:0]);
      default: ld_data_d = ld_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      addr_q          <= '0;
      f3_q            <= '0;
      reg_write_q     <= 1'b0;
      result_src_q    <= '0;
      rd_q            <= '0;
      pc4_q           <= '0;
      req_valid_q     <= 1'b0;
      req_we_q        <= 1'b0;
      req_addr_q      <= '0;
      req_wdata_q     <= '0;
      req_be_q        <= '0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_result_src_q <= '0;
      wb_read_data_q  <= '0;
      wb_alu_result_q <= '0;
      wb_pc_plus_4_q  <= '0;
      wb_rd_addr_q    <= '0;
      exc_misalign_q  <= 1'b0;
      exc_bus_err_q   <= 1'b0;
      exc_addr_q      <= '0;
    end else begin
      wb_valid_q     <= 1'b0;
      exc_misalign_q <= 1'b0;
      exc_bus_err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: if (ex_valid_i) begin
          addr_q       <= ex_alu_result_i;
          f3_q         <= ex_funct3_i;
          reg_write_q  <= ex_reg_write_i;
          result_src_q <= ex_result_src_i;
          rd_q         <= ex_rd_addr_i;
          pc4_q        <= ex_pc_plus_4_i;
          if (is_mem && !(illegal || misal)) begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
            req_we_q    <= ex_mem_write_i;
            req_addr_q  <= ex_alu_result_i & ~XLEN'(NB - 1);
            req_wdata_q <= wdata_d;
            req_be_q    <= be_d;
          end else begin
            // Non-memory ops retire straight away; a trapped access retires without a register write.
            wb_valid_q      <= 1'b1;
            wb_reg_write_q  <= ex_reg_write_i && !is_mem;
            wb_result_src_q <= ex_result_src_i;
            wb_read_data_q  <= '0;
            wb_alu_result_q <= ex_alu_result_i;
            wb_pc_plus_4_q  <= ex_pc_plus_4_i;
            wb_rd_addr_q    <= ex_rd_addr_i;
            exc_misalign_q  <= is_mem;
            if (is_mem) exc_addr_q <= ex_alu_result_i;
          end
        end
        S_REQ: if (dmem.req_ready) begin
          req_valid_q <= 1'b0;
          cnt_q       <= '0;
          if (req_we_q) begin
            state_q         <= S_IDLE;
            wb_valid_q      <= 1'b1;
            wb_reg_write_q  <= reg_write_q;
            wb_result_src_q <= result_src_q;
            wb_read_data_q  <= '0;
            wb_alu_result_q <= addr_q;
            wb_pc_plus_4_q  <= pc4_q;
            wb_rd_addr_q    <= rd_q;
          end else begin
            state_q <= S_RSP;
          end
        end
        S_RSP: begin
          // A response arriving in the timeout cycle still completes the load normally.
          if (dmem.rsp_valid || timeout_hit) begin
            state_q         <= S_IDLE;
            wb_valid_q      <= 1'b1;
            wb_reg_write_q  <= reg_write_q && dmem.rsp_valid;
            wb_result_src_q <= result_src_q;
            wb_read_data_q  <= dmem.rsp_valid ? ld_data_d : '0;
            wb_alu_result_q <= addr_q;
            wb_pc_plus_4_q  <= pc4_q;
            wb_rd_addr_q    <= rd_q;
            exc_bus_err_q   <= !dmem.rsp_valid;
            if (!dmem.rsp_valid) exc_addr_q <= addr_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ex_ready_o      = (state_q == S_IDLE) && rst_n;
  assign dmem.req_valid  = req_valid_q;
  assign dmem.req_we     = req_we_q;
  assign dmem.req_addr   = req_addr_q;
  assign dmem.req_wdata  = req_wdata_q;
  assign dmem.req_be     = req_be_q;
  assign wb_valid_o      = wb_valid_q;
  assign wb_reg_write_o  = wb_reg_write_q;
  assign wb_result_src_o = wb_result_src_q;
  assign wb_read_data_o  = wb_read_data_q;
  assign wb_alu_result_o = wb_alu_result_q;
  assign wb_pc_plus_4_o  = wb_pc_plus_4_q;
  assign wb_rd_addr_o    = wb_rd_addr_q;
  assign exc_misalign_o  = exc_misalign_q;
  assign exc_bus_err_o   = exc_bus_err_q;
  assign exc_addr_o      = exc_addr_q;
  assign dbg_state_o     = state_q;
endmodule
